// File: rtl/simon_pkg.sv
// Shared constants, state encodings and word helpers for the SIMON 128/256 core.
package simon_pkg;

  localparam int N  = 64;
  localparam int M  = 4;
  localparam int T  = 72;
  localparam int CO = 7;
  localparam int KEXP_STEPS = T - M;

  localparam logic [N-1:0] C_CONST = 64'hFFFF_FFFF_FFFF_FFFC;
  // z[0] is the leftmost (MSB) bit of this literal
  localparam logic [61:0]  Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

  typedef enum logic [1:0] {NOKEY, KLOAD, KEXP, KREADY} key_state_t;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} data_state_t;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Indices past 123 only occur for discarded backward steps; they map to 0.
  function automatic logic zBit(input logic [CO-1:0] idx);
    logic [CO-1:0] zi;
    logic [5:0]    pos;
    zi  = (idx >= CO'(62)) ? idx - CO'(62) : idx;
    pos = 6'(CO'(61) - zi);
    if (zi < CO'(62)) return Z4[pos];
    return 1'b0;
  endfunction

endpackage

// File: rtl/simon_key_step.sv
// One forward or backward step of the four-word SIMON key window.
module simon_key_step import simon_pkg::*; (
  input  logic [M-1:0][N-1:0] winIn,
  input  logic                fwd,
  input  logic [CO-1:0]       idx,
  output logic [M-1:0][N-1:0] winOut
);

  logic [N-1:0] zWord, tmpF, tmpB, kNew, kOld;

  // Forward: window k[i..i+3] -> k[i+1..i+4]; backward: k[i+1..i+4] -> k[i..i+3].
  always_comb begin
    zWord  = {{(N-1){1'b0}}, zBit(idx)};
    tmpF   = ror(winIn[3], 3) ^ winIn[1];
    kNew   = C_CONST ^ zWord ^ winIn[0] ^ tmpF ^ ror(tmpF, 1);
    tmpB   = ror(winIn[2], 3) ^ winIn[0];
    kOld   = winIn[3] ^ C_CONST ^ zWord ^ tmpB ^ ror(tmpB, 1);
    winOut = fwd ? {kNew, winIn[3], winIn[2], winIn[1]}
                 : {winIn[2], winIn[1], winIn[0], kOld};
  end

endmodule

// File: rtl/simon_128_256.sv
// SIMON 128/256 core: one round per clock with on-the-fly round keys.
//   key state | meaning
//   NOKEY     | no key loaded, waiting for newKey
//   KLOAD     | capture master key (loadKey pulse visible)
//   KEXP      | 68 forward steps to reach k68..k71
//   KREADY    | key schedule ready (doneKey)
//   data state| meaning
//   IDLE      | waiting for newData with a ready key
//   LOAD      | capture block and direction (loadData pulse visible)
//   RUN       | 72 rounds
//   DONE      | result held until readData
module simon_128_256 import simon_pkg::*; (
  input  logic                clk,
  input  logic                nR,
  input  logic                newData,
  input  logic                newKey,
  input  logic                enc_dec,
  input  logic                readData,
  input  logic [1:0][N-1:0]   blockIN,
  input  logic [M-1:0][N-1:0] KEY,
  output logic                loadData,
  output logic                loadKey,
  output logic                doneData,
  output logic                doneKey,
  output logic [1:0][N-1:0]   outData,
  output logic [3:0]          mode
);

  key_state_t          keyState;
  data_state_t         dataState;
  logic [M-1:0][N-1:0] masterKey, lastKey, kwin, kwinNext;
  logic [N-1:0]        x, y, nextX, nextY;
  logic                encReg;
  logic [CO-1:0]       keyCnt, rndCnt, roundIdx, stepIdx;
  logic                stepFwd, dataRun;

  assign mode = {keyState, dataState};

  // The two FSMs never step the window at the same time, so one key step serves both.
  always_comb begin
    dataRun  = (dataState == RUN);
    roundIdx = encReg ? CO'(T - 1) - rndCnt : rndCnt;
    stepFwd  = dataRun ? encReg : 1'b1;
    if (dataRun) stepIdx = encReg ? roundIdx : roundIdx - CO'(4);
    else         stepIdx = CO'(KEXP_STEPS - 1) - keyCnt;
    nextX = encReg ? (y ^ f(x) ^ kwin[0]) : y;
    nextY = encReg ? x : (x ^ f(y) ^ kwin[3]);
  end

  simon_key_step uKeyStep (
    .winIn  (kwin),
    .fwd    (stepFwd),
    .idx    (stepIdx),
    .winOut (kwinNext)
  );

  always_ff @(posedge clk) begin
    if (nR) begin
      keyState  <= NOKEY;
      dataState <= IDLE;
      loadData  <= 1'b0;
      loadKey   <= 1'b0;
      doneData  <= 1'b0;
      doneKey   <= 1'b0;
      outData   <= '0;
      masterKey <= '0;
      lastKey   <= '0;
      kwin      <= '0;
      x         <= '0;
      y         <= '0;
      encReg    <= 1'b0;
      keyCnt    <= '0;
      rndCnt    <= '0;
    end else begin
      loadKey  <= 1'b0;
      loadData <= 1'b0;

      case (keyState)
        NOKEY: begin
          if (newKey) begin
            keyState <= KLOAD;
            loadKey  <= 1'b1;
          end
        end
        KLOAD: begin
          masterKey <= KEY;
          kwin      <= KEY;
          keyCnt    <= CO'(KEXP_STEPS - 1);
          keyState  <= KEXP;
        end
        KEXP: begin
          kwin <= kwinNext;
          if (keyCnt == '0) begin
            lastKey  <= kwinNext;
            doneKey  <= 1'b1;
            keyState <= KREADY;
          end else begin
            keyCnt <= keyCnt - CO'(1);
          end
        end
        KREADY: begin
          if (newKey && dataState == IDLE) begin
            keyState <= KLOAD;
            loadKey  <= 1'b1;
            doneKey  <= 1'b0;
          end
        end
        default: keyState <= NOKEY;
      endcase

      case (dataState)
        IDLE: begin
          // a simultaneous newKey wins; the key FSM takes KLOAD this cycle
          if (newData && !newKey && keyState == KREADY) begin
            dataState <= LOAD;
            loadData  <= 1'b1;
          end
        end
        LOAD: begin
          x         <= blockIN[1];
          y         <= blockIN[0];
          encReg    <= enc_dec;
          kwin      <= enc_dec ? masterKey : lastKey;
          rndCnt    <= CO'(T - 1);
          dataState <= RUN;
        end
        RUN: begin
          x    <= nextX;
          y    <= nextY;
          kwin <= kwinNext;
          if (rndCnt == '0) begin
            outData   <= {nextX, nextY};
            doneData  <= 1'b1;
            dataState <= DONE;
          end else begin
            rndCnt <= rndCnt - CO'(1);
          end
        end
        DONE: begin
          if (readData) begin
            doneData  <= 1'b0;
            dataState <= IDLE;
          end
        end
        default: dataState <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_128_256.sv
// Directed bench for simon_128_256 with a reference SIMON model and result scoreboard.
module tb_simon_128_256;

  logic             clk = 1'b0;
  logic             nR = 1'b1, newData = 1'b0, newKey = 1'b0, enc_dec = 1'b0, readData = 1'b0;
  logic [1:0][63:0] blockIN = '0;
  logic [3:0][63:0] KEY = '0;
  logic             loadData, loadKey, doneData, doneKey;
  logic [1:0][63:0] outData;
  logic [3:0]       mode;

  simon_128_256 dut (
    .clk(clk), .nR(nR), .newData(newData), .newKey(newKey), .enc_dec(enc_dec),
    .readData(readData), .blockIN(blockIN), .KEY(KEY), .loadData(loadData),
    .loadKey(loadKey), .doneData(doneData), .doneKey(doneKey), .outData(outData),
    .mode(mode)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, loadCnt = 0, loadAt = 0, doneAt = 0, keyAt = 0, keyDoneAt = 0, relAt = 0;
  logic earlyLoad = 1'b0;
  logic [127:0] sbq[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (loadData) loadCnt <= loadCnt + 1;
  end

  always @(negedge clk) if (loadData && !doneKey) earlyLoad <= 1'b1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mrol(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  function automatic logic [63:0] mror(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  // Reference: full round-key array expanded up front, then 72 rounds.
  function automatic logic [127:0] simonEnc(input logic [3:0][63:0] k4, input logic [127:0] pt);
    logic [63:0] rk [72];
    logic [63:0] tmp, xv, yv, tv;
    logic [61:0] zs;
    logic [5:0]  zp;
    zs = 62'b11010001111001101011011000100000010111000011001010010011101111;
    for (int i = 0; i < 4; i++) rk[i] = k4[i];
    for (int i = 0; i < 68; i++) begin
      zp = 6'(61 - (i % 62));
      tmp = mror(rk[i+3], 3) ^ rk[i+1];
      rk[i+4] = ~rk[i] ^ tmp ^ mror(tmp, 1) ^ 64'd3 ^ {63'b0, zs[zp]};
    end
    xv = pt[127:64];
    yv = pt[63:0];
    for (int i = 0; i < 72; i++) begin
      tv = xv;
      xv = yv ^ (mrol(xv, 1) & mrol(xv, 8)) ^ mrol(xv, 2) ^ rk[i];
      yv = tv;
    end
    return {xv, yv};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return loadKey;
      1:       return doneKey;
      2:       return loadData;
      default: return doneData;
    endcase
  endfunction

  task automatic waitFor(input int sel, input string tag, input int budget, output int atCyc);
    int n = 0;
    while (sig(sel) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, " seen"}, 128'(sig(sel)), 128'd1);
    atCyc = cyc;
  endtask

  task automatic loadKeyTask(input logic [3:0][63:0] k);
    KEY = k;
    newKey = 1'b1;
    waitFor(0, "loadKey", 300, keyAt);
    newKey = 1'b0;
    chk("KLOAD mode/doneKey", 128'({mode, doneKey}), 128'({4'h4, 1'b0}));
    waitFor(1, "doneKey", 200, keyDoneAt);
    chk("key latency", 128'(keyDoneAt - keyAt), 128'd69);
    chk("KREADY mode", 128'(mode), 128'hC);
  endtask

  task automatic startBlock(input logic [127:0] blk, input logic enc, input logic [127:0] expv);
    blockIN = blk;
    enc_dec = enc;
    newData = 1'b1;
    waitFor(2, "loadData", 300, loadAt);
    newData = 1'b0;
    sbq.push_back(expv);
    tick();
    chk("loadData pulse", 128'(loadData), 128'd0);
  endtask

  task automatic finishBlock();
    logic [127:0] expv;
    waitFor(3, "doneData", 200, doneAt);
    chk("data latency", 128'(doneAt - loadAt), 128'd73);
    expv = (sbq.size() > 0) ? sbq.pop_front() : 128'bx;
    chk("outData", outData, expv);
  endtask

  task automatic releaseResult();
    readData = 1'b1;
    tick();
    readData = 1'b0;
    chk("doneData drop", 128'(doneData), 128'd0);
    relAt = cyc;
  endtask

  localparam logic [127:0] PT0 = 128'h74206E69206D6F6F6D69732061207369;
  localparam logic [127:0] CT0 = 128'h8D2B5579AFC8A3A03BF72A87EFE7B868;

  logic [3:0][63:0] key;
  logic [127:0] pts [5];
  logic [127:0] cts [5];
  int loads0;

  initial begin
    key[3] = 64'h1F1E1D1C1B1A1918;
    key[2] = 64'h1716151413121110;
    key[1] = 64'h0F0E0D0C0B0A0908;
    key[0] = 64'h0706050403020100;
    pts[0] = PT0;
    pts[1] = 128'hA8D5F7DE0123FEDC01234567FEDCBA98;
    pts[2] = 128'h5BC92D014567BA9889ABCDEF01234567;
    pts[3] = 128'hF2B48D4589AB765401234567FEDCBA98;
    pts[4] = 128'h567F11DECDEF321089ABCDEF01234567;
    for (int i = 0; i < 5; i++) cts[i] = simonEnc(key, pts[i]);

    // reset state
    nR = 1'b1;
    repeat (3) tick();
    chk("reset outputs", 128'({loadData, loadKey, doneData, doneKey, mode}), 128'd0);
    chk("reset outData", outData, 128'd0);
    nR = 1'b0;

    // newData with no key: must wait for the key schedule
    blockIN = PT0;
    enc_dec = 1'b1;
    newData = 1'b1;
    repeat (10) tick();
    chk("no load without key", 128'({loadData, mode}), 128'd0);
    loadKeyTask(key);
    startBlock(PT0, 1'b1, CT0);
    finishBlock();

    // hold result without readData while a new request waits
    blockIN = CT0;
    enc_dec = 1'b0;
    newData = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold", {doneData, loadData, outData}, {1'b1, 1'b0, CT0});
    end
    releaseResult();
    chk("no load on release", 128'(loadData), 128'd0);
    startBlock(CT0, 1'b0, PT0);
    chk("reload gap", 128'(loadAt - relAt), 128'd1);
    finishBlock();
    releaseResult();

    // newKey during RUN is deferred to IDLE
    startBlock(pts[1], 1'b1, cts[1]);
    repeat (10) tick();
    KEY = key;
    newKey = 1'b1;
    repeat (5) tick();
    chk("newKey deferred", 128'({loadKey, doneKey, mode}), 128'({1'b0, 1'b1, 4'hE}));
    finishBlock();
    releaseResult();
    chk("no key load on release", 128'(loadKey), 128'd0);
    loadKeyTask(key);

    // stream of five encryptions
    loads0 = loadCnt;
    for (int i = 0; i < 5; i++) begin
      startBlock(pts[i], 1'b1, cts[i]);
      finishBlock();
      releaseResult();
    end
    tick();
    chk("encrypt load count", 128'(loadCnt - loads0), 128'd5);

    nR = 1'b1;
    tick();
    nR = 1'b0;
    chk("reset between streams", 128'({doneKey, mode}), 128'd0);
    loadKeyTask(key);
    loads0 = loadCnt;
    for (int i = 0; i < 5; i++) begin
      startBlock(cts[i], 1'b0, pts[i]);
      finishBlock();
      releaseResult();
    end
    tick();
    chk("decrypt load count", 128'(loadCnt - loads0), 128'd5);

    // reset mid-RUN at round 30
    startBlock(pts[2], 1'b1, cts[2]);
    repeat (30) tick();
    chk("mode in RUN", 128'(mode), 128'hE);
    nR = 1'b1;
    tick();
    chk("abort outputs", 128'({loadData, loadKey, doneData, doneKey, mode}), 128'd0);
    chk("abort outData", outData, 128'd0);
    sbq.delete();
    nR = 1'b0;
    tick();
    loadKeyTask(key);
    startBlock(pts[3], 1'b1, cts[3]);
    finishBlock();
    releaseResult();

    chk("loadData before doneKey", 128'(earlyLoad), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_128_256.md
Name: simon_128_256

Overview:
- SIMON 128/256 block-cipher core: 128-bit block, 256-bit key, 72 rounds, one round per clock.
- Encrypts or decrypts one block at a time using a level/pulse handshake with a host controller.
- Round keys are generated on the fly: forward for encryption, backward for decryption.
- Sits between a host data/key interface and downstream consumers of the result.

Parameters:
- N, 64, word width (block = 2 words).
- M, 4, key words.
- T, 72, rounds.
- Co, 7, round/key counter width.
- Only the defaults are supported.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- nR  in  1  reset, synchronous, active-high (1 = reset).
- newData  in  1  level: blockIN is valid and requests processing.
- newKey  in  1  level: KEY is valid and requests key setup.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled at the data load.
- readData  in  1  host has read outData.
- blockIN  in  2xN  [1] = x (high word), [0] = y (low word).
- KEY  in  MxN  KEY[0] = k0 … KEY[3] = k3.
- loadData  out  1  one-cycle pulse when blockIN is captured.
- loadKey  out  1  one-cycle pulse when KEY is captured.
- doneData  out  1  result valid on outData.
- doneKey  out  1  key schedule ready.
- outData  out  2xN  result, same word order as blockIN.
- mode  out  4  {key_state[1:0], data_state[1:0]}.

Behaviour:
- Reset: all outputs 0; both FSMs return to state 0; stored keys and counters are cleared. Reset mid-operation aborts everything.
- f(x) = (rol(x,1) & rol(x,8)) ^ rol(x,2).
- c = 64'hFFFF_FFFF_FFFF_FFFC.
- z4 = 62-bit sequence 11010001111001101011011000100000010111000011001010010011101111, bit z[0] leftmost.
- Key step (forward): tmp = ror(k[i+3],3) ^ k[i+1]; k[i+4] = c ^ z[i mod 62] ^ k[i] ^ tmp ^ ror(tmp,1).
- Key step (backward): k[i] = k[i+4] ^ c ^ z[i mod 62] ^ tmp ^ ror(tmp,1), with tmp computed from k[i+3] and k[i+1].
- Key FSM (key_state):
  - NOKEY(0): on newKey → KLOAD. newKey takes priority over newData when both are high.
  - KLOAD(1): pulse loadKey; store master key k0..k3; window = master; → KEXP.
  - KEXP(2): 68 forward steps, one per cycle; store final window k68..k71; → KREADY with doneKey = 1.
  - KREADY(3): newKey re-enters KLOAD, but only while data_state is IDLE. doneKey drops on entering KLOAD. newKey is ignored in KLOAD and KEXP.
- Data FSM (data_state):
  - IDLE(0): when newData = 1 and key_state = KREADY → LOAD.
  - LOAD(1): pulse loadData; latch blockIN and enc_dec; reset round counter.
    - Encrypt: window = k0..k3.
    - Decrypt: window = k68..k71.
  - RUN(2): 72 cycles.
    - Encrypt round i = 0..71: x' = y ^ f(x) ^ k_i; y' = x. Key window steps forward.
    - Decrypt round i = 71..0: x' = y; y' = x ^ f(y) ^ k_i. Key window steps backward.
  - After the final round: outData = (x,y), doneData = 1 → DONE.
  - DONE(3): hold doneData and outData until readData = 1. Then doneData = 0 next cycle → IDLE.
- newData held high while in DONE is honoured in IDLE, so the next loadData comes 2 cycles after readData at the earliest.
- newData is level-sensitive only in IDLE; it is ignored in LOAD, RUN and DONE.
- outData holds its last result until overwritten or reset.
- Latency: loadData → doneData = 73 cycles. loadKey → doneKey = 69 cycles.

Decomposition:
- simon_pkg:
  - N, M, T constants.
  - C_CONST and Z4 constants.
  - key_state_t and data_state_t enums.
  - Functions f, rol, ror.
- Sub-module simon_key_step: combinational forward/backward key-window update selected by a direction input. The round datapath stays in the top module.

Test Plan:
- Encrypt vector:
  - Stimulus: KEY[3..0] = 1F1E1D1C1B1A1918, 1716151413121110, 0F0E0D0C0B0A0908, 0706050403020100; blockIN = 74206E69206D6F6F6D69732061207369; enc_dec = 1.
  - Required: outData = 8D2B5579AFC8A3A03BF72A87EFE7B868; doneKey 69 cycles after loadKey; doneData 73 cycles after loadData.
- Decrypt vector:
  - Stimulus: same key; blockIN = 8D2B5579AFC8A3A03BF72A87EFE7B868; enc_dec = 0.
  - Required: outData = 74206E69206D6F6F6D69732061207369.
- Stream round-trip:
  - Stimulus: encrypt 5 blocks (the vector above, A8D5F7DE0123FEDC01234567FEDCBA98, 5BC92D014567BA9889ABCDEF01234567, F2B48D4589AB765401234567FEDCBA98, 567F11DECDEF321089ABCDEF01234567) using the readData handshake; reset; reload key; decrypt the 5 outputs.
  - Required: all 5 plaintexts recovered; exactly one loadData per block.
- Handshake hold:
  - Stimulus: withhold readData for 20 cycles after doneData.
  - Required: doneData and outData stable; no loadData even with newData = 1.
  - Then: after readData, doneData = 0 next cycle and the next load follows.
- Reset mid-RUN:
  - Stimulus: assert nR at round 30.
  - Required: next cycle all outputs = 0 and mode = 0; a new newKey/newData sequence gives the correct result.
- Key ordering:
  - Stimulus: newData = 1 with no key, then newKey asserted.
  - Required: no loadData until doneKey = 1.
  - Then: newKey during RUN is deferred until IDLE.
